// File: rtl/unidad_corrimiento_pkg.sv
// Shared opcode encoding and default width for the unidad_corrimiento shift/rotate unit.
package unidad_corrimiento_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_SHL  = 3'b001,
    OP_SHR  = 3'b010,
    OP_ZERO = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ASL  = 3'b110,
    OP_ASR  = 3'b111
  } op_e;

endpackage

// File: rtl/unidad_corrimiento_barril.sv
// corrimiento_barril: combinational N-bit log-stage barrel shifter with
// direction, rotate and fill-bit controls.
module corrimiento_barril #(
  parameter int N  = 4,
  parameter int DW = $clog2(N)
) (
  input  logic [N-1:0]  data_in,
  input  logic [DW-1:0] amt,
  input  logic          left,
  input  logic          rotate,
  input  logic          fill,
  output logic [N-1:0]  data_out
);

  logic [N-1:0] cur;
  logic [N-1:0] nxt;

  // Stage k moves by 2**k; a stage step >= N flushes everything to fill on a
  // shift, while rotates use the step mod N so the total amount wraps mod N.
  always_comb begin
    cur = data_in;
    nxt = data_in;
    for (int k = 0; k < DW; k++) begin
      nxt = cur;
      if (amt[k]) begin
        for (int i = 0; i < N; i++) begin
          if (left) begin
            if (rotate || i >= (1 << k)) nxt[i] = cur[(i + N - ((1 << k) % N)) % N];
            else                          nxt[i] = fill;
          end else begin
            if (rotate || (i + (1 << k)) < N) nxt[i] = cur[(i + ((1 << k) % N)) % N];
            else                              nxt[i] = fill;
          end
        end
      end
      cur = nxt;
    end
    data_out = cur;
  end

endmodule

// File: rtl/unidad_corrimiento.sv
// unidad_corrimiento: registered shift/rotate unit (1-cycle latency).
// Define UNIDAD_CORRIMIENTO_OVF_EN to add the registered ovf output for SHL/ASL.
module unidad_corrimiento
  import unidad_corrimiento_pkg::*;
#(
  parameter int N = N_DEFAULT,
  localparam int DW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  F,
  input  logic [2:0]    H,
  input  logic [DW-1:0] D,
  output logic [N-1:0]  s
`ifdef UNIDAD_CORRIMIENTO_OVF_EN
  ,
  output logic          ovf
`endif
);

  op_e          op;
  logic         sh_left;
  logic         sh_rotate;
  logic         sh_fill;
  logic [N-1:0] sh_out;
  logic [N-1:0] s_d;
  logic [N-1:0] s_q;

  assign op = op_e'(H);

  corrimiento_barril #(
    .N  (N),
    .DW (DW)
  ) u_barril (
    .data_in  (F),
    .amt      (D),
    .left     (sh_left),
    .rotate   (sh_rotate),
    .fill     (sh_fill),
    .data_out (sh_out)
  );

  always_comb begin
    sh_left   = 1'b0;
    sh_rotate = 1'b0;
    sh_fill   = 1'b0;
    s_d       = sh_out;
    case (op)
      OP_PASS: s_d = F;
      OP_SHL,
      OP_ASL:  sh_left = 1'b1;
      OP_SHR:  sh_left = 1'b0;
      OP_ZERO: s_d = '0;
      OP_ROL: begin
        sh_left   = 1'b1;
        sh_rotate = 1'b1;
      end
      OP_ROR:  sh_rotate = 1'b1;
      OP_ASR:  sh_fill = F[N-1];
      default: s_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_q <= '0;
    else     s_q <= s_d;
  end

  assign s = s_q;

`ifdef UNIDAD_CORRIMIENTO_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Any bit in F[N-1:N-1-D] differing from the sign bit is lost or flips the sign.
  always_comb begin
    ovf_d = 1'b0;
    if (op == OP_SHL || op == OP_ASL) begin
      for (int i = 0; i < N - 1; i++) begin
        if ((N - 1 - i) <= int'(D) && F[i] != F[N-1]) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_unidad_corrimiento.sv
// Directed self-checking bench for unidad_corrimiento at N=4.
module tb_unidad_corrimiento;

  logic       clk;
  logic       rst;
  logic [3:0] F;
  logic [2:0] H;
  logic [1:0] D;
  logic [3:0] s;
`ifdef UNIDAD_CORRIMIENTO_OVF_EN
  logic       ovf;
`endif

  int compared;
  int mismatched;

  unidad_corrimiento #(.N(4)) dut (
    .clk (clk),
    .rst (rst),
    .F   (F),
    .H   (H),
    .D   (D),
    .s   (s)
`ifdef UNIDAD_CORRIMIENTO_OVF_EN
    ,
    .ovf (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs mid-cycle, then sample 1 time unit after the next rising edge.
  task automatic apply_and_clock(input logic [3:0] f, input logic [2:0] h, input logic [1:0] d);
    @(negedge clk);
    F = f;
    H = h;
    D = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    F = 4'b1010;
    H = 3'b000;
    D = 2'd0;
    #2;
    compared++;
    if (s !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_initial: s=%b expected=%b", s, 4'b0000);
    end
`ifdef UNIDAD_CORRIMIENTO_OVF_EN
    compared++;
    if (ovf !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_initial_ovf: ovf=%b expected=0", ovf);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_transfer_clear();
    apply_and_clock(4'b1100, 3'b000, 2'd1);
    compared++;
    if (s !== 4'b1100) begin
      mismatched++;
      $display("[TB] FAIL transfer: s=%b expected=%b", s, 4'b1100);
    end
    apply_and_clock(4'b1100, 3'b011, 2'd1);
    compared++;
    if (s !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL clear: s=%b expected=%b", s, 4'b0000);
    end
  endtask

  task automatic test_shifts();
    logic [3:0] shl_exp [3] = '{4'b1000, 4'b0000, 4'b0000};
    logic [3:0] shr_exp [3] = '{4'b0110, 4'b0011, 4'b0001};
    for (int d = 1; d <= 3; d++) begin
      apply_and_clock(4'b1100, 3'b001, 2'(d));
      compared++;
      if (s !== shl_exp[d-1]) begin
        mismatched++;
        $display("[TB] FAIL shl_d%0d: s=%b expected=%b", d, s, shl_exp[d-1]);
      end
      apply_and_clock(4'b1100, 3'b110, 2'(d));
      compared++;
      if (s !== shl_exp[d-1]) begin
        mismatched++;
        $display("[TB] FAIL asl_d%0d: s=%b expected=%b", d, s, shl_exp[d-1]);
      end
      apply_and_clock(4'b1100, 3'b010, 2'(d));
      compared++;
      if (s !== shr_exp[d-1]) begin
        mismatched++;
        $display("[TB] FAIL shr_d%0d: s=%b expected=%b", d, s, shr_exp[d-1]);
      end
    end
  endtask

  task automatic test_rotates();
    logic [3:0] rol_exp [3] = '{4'b1001, 4'b0011, 4'b0110};
    logic [3:0] ror_exp [3] = '{4'b0110, 4'b0011, 4'b1001};
    for (int d = 1; d <= 3; d++) begin
      apply_and_clock(4'b1100, 3'b100, 2'(d));
      compared++;
      if (s !== rol_exp[d-1]) begin
        mismatched++;
        $display("[TB] FAIL rol_d%0d: s=%b expected=%b", d, s, rol_exp[d-1]);
      end
      apply_and_clock(4'b1100, 3'b101, 2'(d));
      compared++;
      if (s !== ror_exp[d-1]) begin
        mismatched++;
        $display("[TB] FAIL ror_d%0d: s=%b expected=%b", d, s, ror_exp[d-1]);
      end
    end
  endtask

  task automatic test_asr();
    logic [3:0] neg_exp [3] = '{4'b1110, 4'b1111, 4'b1111};
    logic [3:0] pos_exp [3] = '{4'b0011, 4'b0001, 4'b0000};
    for (int d = 1; d <= 3; d++) begin
      apply_and_clock(4'b1100, 3'b111, 2'(d));
      compared++;
      if (s !== neg_exp[d-1]) begin
        mismatched++;
        $display("[TB] FAIL asr_neg_d%0d: s=%b expected=%b", d, s, neg_exp[d-1]);
      end
      apply_and_clock(4'b0110, 3'b111, 2'(d));
      compared++;
      if (s !== pos_exp[d-1]) begin
        mismatched++;
        $display("[TB] FAIL asr_pos_d%0d: s=%b expected=%b", d, s, pos_exp[d-1]);
      end
    end
  endtask

  task automatic test_d_zero();
    for (int h = 0; h < 8; h++) begin
      logic [3:0] exp_s;
      exp_s = (h == 3) ? 4'b0000 : 4'b1011;
      apply_and_clock(4'b1011, 3'(h), 2'd0);
      compared++;
      if (s !== exp_s) begin
        mismatched++;
        $display("[TB] FAIL d_zero_h%0d: s=%b expected=%b", h, s, exp_s);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] f_vec [4] = '{4'b0001, 4'b1000, 4'b1001, 4'b0101};
    logic [2:0] h_vec [4] = '{3'b001, 3'b111, 3'b101, 3'b100};
    logic [1:0] d_vec [4] = '{2'd3, 2'd2, 2'd1, 2'd2};
    logic [3:0] e_vec [4] = '{4'b1000, 4'b1110, 4'b1100, 4'b0101};
    logic [3:0] prev;
    prev = s;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      F = f_vec[k];
      H = h_vec[k];
      D = d_vec[k];
      #1;
      compared++;
      if (s !== prev) begin
        mismatched++;
        $display("[TB] FAIL b2b_hold_%0d: s=%b expected=%b", k, s, prev);
      end
      @(posedge clk);
      #1;
      compared++;
      if (s !== e_vec[k]) begin
        mismatched++;
        $display("[TB] FAIL b2b_result_%0d: s=%b expected=%b", k, s, e_vec[k]);
      end
      prev = e_vec[k];
    end
  endtask

  task automatic test_reset_midstream();
    apply_and_clock(4'b1100, 3'b100, 2'd1);
    compared++;
    if (s !== 4'b1001) begin
      mismatched++;
      $display("[TB] FAIL midrst_setup: s=%b expected=%b", s, 4'b1001);
    end
    #2;
    F = 4'b0110;
    H = 3'b000;
    D = 2'd0;
    rst = 1'b1;
    #1;
    compared++;
    if (s !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL midrst_immediate: s=%b expected=%b", s, 4'b0000);
    end
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (s !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL midrst_hold: s=%b expected=%b", s, 4'b0000);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if (s !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL midrst_release_pre_edge: s=%b expected=%b", s, 4'b0000);
    end
    @(posedge clk);
    #1;
    compared++;
    if (s !== 4'b0110) begin
      mismatched++;
      $display("[TB] FAIL midrst_first_load: s=%b expected=%b", s, 4'b0110);
    end
  endtask

`ifdef UNIDAD_CORRIMIENTO_OVF_EN
  task automatic test_ovf();
    apply_and_clock(4'b0110, 3'b110, 2'd1);
    compared++;
    if (s !== 4'b1100 || ovf !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL ovf_asl_lost: s=%b ovf=%b expected s=1100 ovf=1", s, ovf);
    end
    apply_and_clock(4'b1110, 3'b110, 2'd1);
    compared++;
    if (ovf !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ovf_asl_kept: ovf=%b expected=0", ovf);
    end
    apply_and_clock(4'b0110, 3'b001, 2'd0);
    compared++;
    if (ovf !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ovf_d_zero: ovf=%b expected=0", ovf);
    end
    apply_and_clock(4'b0110, 3'b010, 2'd1);
    compared++;
    if (ovf !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ovf_shr: ovf=%b expected=0", ovf);
    end
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_transfer_clear();
    test_shifts();
    test_rotates();
    test_asr();
    test_d_zero();
    test_back_to_back();
    test_reset_midstream();
`ifdef UNIDAD_CORRIMIENTO_OVF_EN
    test_ovf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
